// File: rtl/ip_rx_pkg.sv
// ip_rx_pkg
//   Shared constants, FSM state type and the ones-complement add helper
//   used by the IPv4 receive parser and the checksum accumulator.
package ip_rx_pkg;

  localparam logic [3:0]  IP_VERSION_4     = 4'd4;
  localparam logic [7:0]  IP_HDR_MIN_BYTES = 8'd20;
  localparam logic [31:0] IP_BCAST         = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IP_RX_IDLE    = 3'd0,
    IP_RX_HDR     = 3'd1,
    IP_RX_OPT     = 3'd2,
    IP_RX_PAYLOAD = 3'd3,
    IP_RX_DISCARD = 3'd4
  } ip_rx_state_t;

  // 16-bit ones-complement add with the end-around carry folded back in.
  // A second fold is never needed: 0xFFFF + 0xFF00 folds to at most 0xFF00.
  function automatic logic [15:0] csum_add(input logic [15:0] sum,
                                           input logic [15:0] addend);
    logic [16:0] s;
    s = {1'b0, sum} + {1'b0, addend};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc
//   Byte-serial IPv4 header checksum accumulator. Each enabled byte is
//   added as the high or low half of a 16-bit word, carry folded on the
//   same cycle. clr restarts the sum; a byte presented together with clr
//   becomes the first term of the new sum.
// Ports
//   i_sys_clk  in   1   clock
//   i_rstn     in   1   async active-low reset
//   clr        in   1   restart accumulation
//   byte_en    in   1   add byte_in this cycle
//   byte_in    in   8   header byte
//   is_msb     in   1   byte is the even (high) byte of its word
//   sum        out  16  running ones-complement sum
module ip_csum_acc
  import ip_rx_pkg::*;
(
  input  logic        i_sys_clk,
  input  logic        i_rstn,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic        is_msb,
  output logic [15:0] sum
);

  logic [15:0] addend;
  logic [15:0] base;

  always_comb begin
    addend = is_msb ? {byte_in, 8'h00} : {8'h00, byte_in};
    base   = clr ? 16'h0000 : sum;
  end

  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sum <= 16'h0000;
    end else if (byte_en) begin
      sum <= csum_add(base, addend);
    end else if (clr) begin
      sum <= 16'h0000;
    end
  end

endmodule

// File: rtl/ip_rx.sv
// ip_rx
//   Receive-side IPv4 parser. Consumes the byte stream that follows the
//   Ethernet header, validates the IPv4 header, strips header and options,
//   and forwards the payload with source IP, protocol and payload length.
// Ports
//   i_sys_clk         in   1   system clock
//   i_rstn            in   1   async active-low reset
//   i_packet_en       in   1   byte strobe, high and contiguous for a packet
//   i_packet          in   8   packet byte, first IP header byte first
//   o_datagram_valid  out  1   payload byte valid (1 cycle after input)
//   o_datagram        out  8   payload byte
//   o_datagram_last   out  1   marks payload byte total_len-1
//   o_src_ip          out  32  source IP of last accepted packet
//   o_protocol        out  8   protocol of last accepted packet
//   o_payload_len     out  16  total_len - IHL*4 of last accepted packet
//   o_drop            out  1   pulse: header rejected or truncated
//   o_trunc           out  1   pulse: packet ended inside payload
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for byte 0; checksum held clear
// HDR      | capturing fixed header bytes 1..19
// OPT      | consuming option bytes (checksummed, not forwarded)
// PAYLOAD  | forwarding payload bytes, countdown from payload_len
// DISCARD  | ignoring bytes (pad or rejected packet) until strobe drops
module ip_rx
  import ip_rx_pkg::*;
#(
  parameter logic [31:0] FPGA_IP = 32'hC0A8_0106
) (
  input  logic        i_sys_clk,
  input  logic        i_rstn,
  input  logic        i_packet_en,
  input  logic [7:0]  i_packet,
  output logic        o_datagram_valid,
  output logic [7:0]  o_datagram,
  output logic        o_datagram_last,
  output logic [31:0] o_src_ip,
  output logic [7:0]  o_protocol,
  output logic [15:0] o_payload_len,
  output logic        o_drop,
  output logic        o_trunc
);

  ip_rx_state_t state, state_nxt;

  logic [7:0]  cnt;
  logic [7:0]  idx;
  logic [7:0]  ver_ihl_q;
  logic [15:0] total_len_q;
  logic        mf_q;
  logic [12:0] frag_off_q;
  logic [7:0]  proto_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [15:0] rem_q;
  logic [15:0] csum_q;

  logic [3:0]  ihl;
  logic [7:0]  hdr_bytes;
  logic [15:0] payload_len;
  logic        hdr_active;
  logic [31:0] dst_chk;
  logic [15:0] csum_chk;
  logic        hdr_ok;

  logic        hdr_done;
  logic        accept;
  logic        drop_set;
  logic        trunc_set;
  logic        emit;
  logic        emit_last;

  // The first byte is consumed in IDLE, so its index is always 0 there.
  always_comb begin
    idx         = (state == IP_RX_IDLE) ? 8'd0 : cnt;
    ihl         = ver_ihl_q[3:0];
    hdr_bytes   = {2'b00, ihl, 2'b00};
    payload_len = total_len_q - {8'd0, hdr_bytes};
    hdr_active  = i_packet_en && ((state == IP_RX_IDLE) ||
                                  (state == IP_RX_HDR)  ||
                                  (state == IP_RX_OPT));
  end

  ip_csum_acc u_csum (
    .i_sys_clk (i_sys_clk),
    .i_rstn    (i_rstn),
    .clr       (state == IP_RX_IDLE),
    .byte_en   (hdr_active),
    .byte_in   (i_packet),
    .is_msb    (~idx[0]),
    .sum       (csum_q)
  );

  // The check runs while the last header byte is still on the input, so
  // that byte is merged in here rather than waiting for it to be stored.
  // Header length is a multiple of 4, so the last byte is always a low byte.
  // Without options the last byte is dst[7:0].
  always_comb begin
    dst_chk  = (state == IP_RX_HDR) ? {dst_q[31:8], i_packet} : dst_q;
    csum_chk = csum_add(csum_q, {8'h00, i_packet});
    hdr_ok   = (ver_ihl_q[7:4] == IP_VERSION_4) &&
               (ihl >= 4'd5) &&
               !mf_q && (frag_off_q == 13'd0) &&
               ((dst_chk == FPGA_IP) || (dst_chk == IP_BCAST)) &&
               (total_len_q >= {8'd0, hdr_bytes}) &&
               (csum_chk == 16'hFFFF);
  end

  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IP_RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hdr_done  = 1'b0;
    accept    = 1'b0;
    drop_set  = 1'b0;
    trunc_set = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    case (state)
      IP_RX_IDLE: begin
        if (i_packet_en) state_nxt = IP_RX_HDR;
      end
      IP_RX_HDR: begin
        if (!i_packet_en) begin
          drop_set  = 1'b1;
          state_nxt = IP_RX_IDLE;
        end else if (idx == IP_HDR_MIN_BYTES - 8'd1) begin
          if (ihl > 4'd5) state_nxt = IP_RX_OPT;
          else            hdr_done  = 1'b1;
        end
      end
      IP_RX_OPT: begin
        if (!i_packet_en) begin
          drop_set  = 1'b1;
          state_nxt = IP_RX_IDLE;
        end else if (idx == hdr_bytes - 8'd1) begin
          hdr_done = 1'b1;
        end
      end
      IP_RX_PAYLOAD: begin
        if (!i_packet_en) begin
          trunc_set = 1'b1;
          state_nxt = IP_RX_IDLE;
        end else begin
          emit = 1'b1;
          if (rem_q == 16'd1) begin
            emit_last = 1'b1;
            state_nxt = IP_RX_DISCARD;
          end
        end
      end
      IP_RX_DISCARD: begin
        if (!i_packet_en) state_nxt = IP_RX_IDLE;
      end
      default: state_nxt = IP_RX_IDLE;
    endcase

    if (hdr_done) begin
      if (hdr_ok) begin
        accept    = 1'b1;
        state_nxt = (payload_len == 16'd0) ? IP_RX_DISCARD : IP_RX_PAYLOAD;
      end else begin
        drop_set  = 1'b1;
        state_nxt = IP_RX_DISCARD;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= 8'd0;
    end else begin
      cnt <= hdr_active ? idx + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ver_ihl_q   <= 8'd0;
      total_len_q <= 16'd0;
      mf_q        <= 1'b0;
      frag_off_q  <= 13'd0;
      proto_q     <= 8'd0;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
    end else if (i_packet_en && ((state == IP_RX_IDLE) || (state == IP_RX_HDR))) begin
      case (idx)
        8'd0:  ver_ihl_q          <= i_packet;
        8'd2:  total_len_q[15:8]  <= i_packet;
        8'd3:  total_len_q[7:0]   <= i_packet;
        8'd6: begin
          mf_q               <= i_packet[5];
          frag_off_q[12:8]   <= i_packet[4:0];
        end
        8'd7:  frag_off_q[7:0]    <= i_packet;
        8'd9:  proto_q            <= i_packet;
        8'd12: src_q[31:24]       <= i_packet;
        8'd13: src_q[23:16]       <= i_packet;
        8'd14: src_q[15:8]        <= i_packet;
        8'd15: src_q[7:0]         <= i_packet;
        8'd16: dst_q[31:24]       <= i_packet;
        8'd17: dst_q[23:16]       <= i_packet;
        8'd18: dst_q[15:8]        <= i_packet;
        8'd19: dst_q[7:0]         <= i_packet;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rem_q            <= 16'd0;
      o_datagram_valid <= 1'b0;
      o_datagram       <= 8'd0;
      o_datagram_last  <= 1'b0;
      o_src_ip         <= 32'd0;
      o_protocol       <= 8'd0;
      o_payload_len    <= 16'd0;
      o_drop           <= 1'b0;
      o_trunc          <= 1'b0;
    end else begin
      if (accept) begin
        rem_q         <= payload_len;
        o_src_ip      <= src_q;
        o_protocol    <= proto_q;
        o_payload_len <= payload_len;
      end else if (emit) begin
        rem_q <= rem_q - 16'd1;
      end
      o_datagram_valid <= emit;
      if (emit) o_datagram <= i_packet;
      o_datagram_last  <= emit_last;
      o_drop           <= drop_set;
      o_trunc          <= trunc_set;
    end
  end

endmodule
